// File: rtl/seq_multiplier_unit_pkg.sv
// Shared constants for the sequential shift-add multiplier.
// This file holds the operation codes, the FSM state encoding and the op decode helper.
package seq_multiplier_unit_pkg;

    localparam int WORD = 64;

    localparam logic [1:0] MULT_OP_MUL   = 2'd0;
    localparam logic [1:0] MULT_OP_SMULH = 2'd1;
    localparam logic [1:0] MULT_OP_UMULH = 2'd2;

    localparam logic [1:0] MULT_IDLE = 2'd0;
    localparam logic [1:0] MULT_RUN  = 2'd1;
    localparam logic [1:0] MULT_FIX  = 2'd2;
    localparam logic [1:0] MULT_DONE = 2'd3;

    // Op code 3 decodes as MUL, so it selects the low half.
    function automatic logic op_selects_high(input logic [1:0] op);
        return (op == MULT_OP_SMULH) || (op == MULT_OP_UMULH);
    endfunction

endpackage

// File: rtl/seq_multiplier_unit.sv
// Radix-2 shift-add multiplier with fixed latency for MUL, SMULH and UMULH.
// SMULH multiplies the operand magnitudes and negates the 2*WIDTH product at the end.
module seq_multiplier_unit
    import seq_multiplier_unit_pkg::*;
#(
    parameter  int WIDTH = WORD,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]         state_q,  state_d;
    logic [1:0]         op_q,     op_d;
    logic               neg_q,    neg_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept;
    logic               is_smulh;
    logic [2*WIDTH-1:0] acc_fixed;

    // MIN_INT negates to itself, which reads correctly as the unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic take_abs);
        return (take_abs && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept    = start && ((state_q == MULT_IDLE) || (state_q == MULT_DONE));
    assign is_smulh  = (op == MULT_OP_SMULH);
    assign acc_fixed = neg_q ? -acc_q : acc_q;

    assign stall  = (state_q == MULT_RUN) || (state_q == MULT_FIX) || accept;
    assign done   = (state_q == MULT_DONE);
    assign result = result_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            MULT_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MULT_FIX;
                end
            end
            MULT_FIX: begin
                acc_d    = acc_fixed;
                result_d = op_selects_high(op_q) ? acc_fixed[2*WIDTH-1:WIDTH] : acc_fixed[WIDTH-1:0];
                state_d  = MULT_DONE;
            end
            MULT_DONE: state_d = MULT_IDLE;
            default:   state_d = state_q;
        endcase

        // A start seen in IDLE or DONE launches a new operation and overrides the case above.
        if (accept) begin
            op_d     = op;
            neg_d    = is_smulh && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            mcand_d  = {{WIDTH{1'b0}}, magnitude(operand_a, is_smulh)};
            mplier_d = magnitude(operand_b, is_smulh);
            acc_d    = '0;
            count_d  = '0;
            state_d  = MULT_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MULT_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking updates make all registers take their next values together at the edge.
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier_unit.sv
// Scoreboard bench for seq_multiplier_unit: directed cases plus random ops against a 128-bit arithmetic model.
// The driver queues expected results at acceptance, and the monitor pops one on every done pulse.
module tb_seq_multiplier_unit;
    import seq_multiplier_unit_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         stall;
    logic         done;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int           acc_cycle;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cycle_cnt = 0;
    int   done_cnt  = 0;

    seq_multiplier_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Reference model built from full-width signed and unsigned products.
    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sp;
        logic        [2*W-1:0] up;
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            MULT_OP_SMULH: return sp[2*W-1:W];
            MULT_OP_UMULH: return up[2*W-1:W];
            default:       return up[W-1:0];
        endcase
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '1;
            3:       return W'(1);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation in both value and timing.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("stall_in_done", W'(stall), W'(start));
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done with result %h, expected no done", result);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("latency", W'(cycle_cnt), W'(e.acc_cycle + W + 1));
            end
        end
    end

    // Issue is called at a negedge while the DUT is in IDLE or DONE. It returns at the negedge after acceptance.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit has_exp, input logic [W-1:0] exp_v);
        exp_t e;
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        #1;
        check("stall_on_start", W'(stall), W'(1));
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
        op        = 2'($urandom_range(0, 3));
        e.res       = has_exp ? exp_v : ref_model(o, a, b);
        e.acc_cycle = cycle_cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: got no done within 200 cycles, expected a done");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int snap;
        reset     = 1'b0;
        start     = 1'b0;
        op        = MULT_OP_MUL;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset_stall",  W'(stall), W'(0));
        check("reset_done",   W'(done),  W'(0));
        check("reset_result", result,    '0);
        reset = 1'b1;
        @(negedge clk);

        // MUL 3*5: count the cycles with stall high, from raising start until done.
        op = MULT_OP_MUL; operand_a = W'(3); operand_b = W'(5); start = 1'b1;
        #1;
        cnt = stall ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        sb_q.push_back('{res: W'(15), acc_cycle: cycle_cnt});
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) break;
            if (stall === 1'b1) cnt++;
            @(negedge clk);
        end
        check("stall_cycles", W'(cnt), W'(66));
        @(negedge clk);
        check("done_one_cycle", W'(done), W'(0));

        issue(MULT_OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFD, W'(5), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF); wait_done();
        issue(MULT_OP_MUL,   64'hFFFF_FFFF_FFFF_FFFD, W'(5), 1'b1, 64'hFFFF_FFFF_FFFF_FFF1); wait_done();
        issue(MULT_OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, W'(2), 1'b1, W'(1));                   wait_done();
        issue(MULT_OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, W'(2), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF); wait_done();
        issue(MULT_OP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000); wait_done();
        issue(2'd3, W'(3), W'(5), 1'b1, W'(15)); wait_done();

        // Busy: a second start during RUN is ignored. A start in the DONE cycle is accepted.
        issue(MULT_OP_MUL, W'(7), W'(6), 1'b1, W'(42));
        repeat (9) @(negedge clk);
        op = MULT_OP_MUL; operand_a = W'(9); operand_b = W'(9); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("stall_busy", W'(stall), W'(1));
        wait_done();
        issue(MULT_OP_MUL, W'(2), W'(2), 1'b1, W'(4));
        wait_done();

        // Asynchronous reset in the middle of RUN.
        issue(MULT_OP_UMULH, rand_operand(), rand_operand(), 1'b0, '0);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_stall",  W'(stall), W'(0));
        check("midrun_reset_done",   W'(done),  W'(0));
        check("midrun_reset_result", result,    '0);
        sb_q.delete();
        snap = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("no_done_after_reset", W'(done_cnt), W'(snap));

        // Random ops, issued back-to-back in each DONE cycle.
        for (int i = 0; i < 1000; i++) begin
            issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'b0, '0);
            wait_done();
        end
        repeat (5) @(negedge clk);
        check("scoreboard_empty", W'(sb_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
